// File: rtl/tile_reader.sv
// Tile reader: fetches a TileRows x TileCols window of a row-major matrix,
// zero-filling elements that fall outside the matrix, then holds the tile.
module tile_reader #(
  parameter int AddrWidth = 16,
  parameter int DataWidth = 8,
  parameter int TileRows  = 4,
  parameter int TileCols  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 transpose_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [15:0]          matrix_rows_i,
  input  logic [15:0]          matrix_cols_i,
  input  logic [15:0]          start_row_i,
  input  logic [15:0]          start_col_i,
  output logic                 busy_o,
  output logic                 mem_req_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  input  logic                 mem_gnt_i,
  input  logic                 mem_rvalid_i,
  input  logic [DataWidth-1:0] mem_rdata_i,
  output logic                 tile_valid_o,
  input  logic                 tile_ready_i,
  output logic [TileRows-1:0][TileCols-1:0][DataWidth-1:0] tile_o,
  output logic                 done_o
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    HOLD
  } state_e;

  localparam logic [4:0] LastR  = 5'(TileRows - 1);
  localparam logic [4:0] LastC  = 5'(TileCols - 1);
  localparam bit         Square = (TileRows == TileCols);

  state_e state_q, state_d;

  logic [AddrWidth-1:0] base_q;
  logic [15:0]          rows_q;
  logic [15:0]          cols_q;
  logic [15:0]          srow_q;
  logic [15:0]          scol_q;
  logic                 tr_q;

  logic [4:0] r_q, c_q;
  logic [4:0] pr_q, pc_q;
  logic       pend_q;
  logic       done_q;
  logic [TileRows-1:0][TileCols-1:0][DataWidth-1:0] tile_q;

  logic [4:0]  off_r, off_c;
  logic [16:0] gr, gc;
  logic [31:0] addr_full;
  logic        inb;
  logic        issue;
  logic        grant;
  logic        advance;
  logic        last;
  logic        zero_wr;
  logic        rsp_wr;

  // 17-bit coordinates so origin + offset cannot wrap back into bounds
  assign off_r = tr_q ? c_q : r_q;
  assign off_c = tr_q ? r_q : c_q;
  assign gr    = {1'b0, srow_q} + {12'd0, off_r};
  assign gc    = {1'b0, scol_q} + {12'd0, off_c};
  assign inb   = (gr < {1'b0, rows_q}) && (gc < {1'b0, cols_q});

  assign addr_full = 32'(base_q)
                   + ({15'd0, gr} * {16'd0, cols_q})
                   + {15'd0, gc};

  assign issue   = (state_q == ISSUE);
  assign grant   = issue && inb && mem_gnt_i;
  assign advance = issue && (!inb || mem_gnt_i);
  assign last    = (r_q == LastR) && (c_q == LastC);
  assign zero_wr = issue && !inb;
  assign rsp_wr  = pend_q && mem_rvalid_i;

  assign busy_o       = (state_q != IDLE);
  assign mem_req_o    = issue && inb;
  assign mem_addr_o   = addr_full[AddrWidth-1:0];
  assign tile_valid_o = (state_q == HOLD);
  assign tile_o       = tile_q;
  assign done_o       = done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start_i) state_d = ISSUE;
      ISSUE: if (advance && last) state_d = DRAIN;
      DRAIN: if (!pend_q || mem_rvalid_i) state_d = HOLD;
      HOLD:  if (tile_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_q <= '0;
      rows_q <= '0;
      cols_q <= '0;
      srow_q <= '0;
      scol_q <= '0;
      tr_q   <= 1'b0;
      r_q    <= '0;
      c_q    <= '0;
      pr_q   <= '0;
      pc_q   <= '0;
      pend_q <= 1'b0;
      done_q <= 1'b0;
      tile_q <= '0;
    end else begin
      done_q <= (state_q == HOLD) && tile_ready_i;
      if ((state_q == IDLE) && start_i) begin
        base_q <= base_addr_i;
        rows_q <= matrix_rows_i;
        cols_q <= matrix_cols_i;
        srow_q <= start_row_i;
        scol_q <= start_col_i;
        tr_q   <= transpose_i && Square;
        r_q    <= '0;
        c_q    <= '0;
      end
      if (advance) begin
        if (c_q == LastC) begin
          c_q <= '0;
          r_q <= r_q + 5'd1;
        end else begin
          c_q <= c_q + 5'd1;
        end
      end
      if (grant) begin
        pend_q <= 1'b1;
        pr_q   <= r_q;
        pc_q   <= c_q;
      end else if (mem_rvalid_i) begin
        pend_q <= 1'b0;
      end
      // response and zero-fill always hit different elements
      for (int i = 0; i < TileRows; i++) begin
        for (int j = 0; j < TileCols; j++) begin
          if (rsp_wr && pr_q == 5'(i) && pc_q == 5'(j))
            tile_q[i][j] <= mem_rdata_i;
          if (zero_wr && r_q == 5'(i) && c_q == 5'(j))
            tile_q[i][j] <= '0;
        end
      end
    end
  end

endmodule

// File: doc/tile_reader.md
TILE_READER -- requirements
Module: tile_reader

Interface
REQ-001 SHALL have parameter AddrWidth, default 16: word address width.
REQ-002 SHALL have parameter DataWidth, default 8: signed element width; one element per memory word.
REQ-003 SHALL have parameter TileRows, default 4: tile rows, range 1..16.
REQ-004 SHALL have parameter TileCols, default 4: tile columns, range 1..16.
REQ-005 SHALL have ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous reset, active-low.
- start_i  in  1  start request, sampled only in IDLE.
- transpose_i  in  1  transpose mode, latched with start.
- base_addr_i  in  AddrWidth  matrix base word address.
- matrix_rows_i  in  16  matrix row count, used for bounds.
- matrix_cols_i  in  16  matrix column count, used as stride and for bounds.
- start_row_i  in  16  tile origin row.
- start_col_i  in  16  tile origin column.
- busy_o  out  1  high whenever the state is not IDLE.
- mem_req_o  out  1  read request.
- mem_addr_o  out  AddrWidth  read address.
- mem_gnt_i  in  1  request accepted this cycle.
- mem_rvalid_i  in  1  read data valid; asserted exactly one cycle after each grant.
- mem_rdata_i  in  DataWidth  read data.
- tile_valid_o  out  1  tile complete and held.
- tile_ready_i  in  1  consumer accepts the tile.
- tile_o  out  TileRows x TileCols x DataWidth  row-major signed tile.
- done_o  out  1  one-cycle pulse on tile acceptance.

Function
REQ-006 SHALL latch base, rows, cols, start_row, start_col and transpose on the cycle start_i is high in IDLE; later input changes SHALL have no effect until the next start.
REQ-007 SHALL use the FSM states IDLE, ISSUE, DRAIN and HOLD:
- IDLE->ISSUE on start.
- ISSUE->DRAIN after the last element is issued.
- DRAIN->HOLD when no response is outstanding.
- HOLD->IDLE on tile_ready_i.
REQ-008 SHALL visit tile element index (r,c) in row-major order, one element per issue slot.
REQ-009 SHALL use source coordinates (gr,gc) = (start_row+r, start_col+c), or (start_row+c, start_col+r) when transpose is set.
REQ-010 SHALL compute address = base + gr*matrix_cols + gc at 32-bit width or wider, truncated to AddrWidth; wrap-around is permitted.
REQ-011 SHALL treat an element as in bounds when gr < matrix_rows and gc < matrix_cols.
REQ-012 For an in-bounds element, SHALL hold mem_req_o high with a stable address until mem_gnt_i, then advance.
REQ-013 For an out-of-bounds element, SHALL NOT request; it SHALL write 0 to tile_o[r][c] and advance in one cycle.
REQ-014 SHALL keep at most one response outstanding, recording its (r,c).
REQ-015 SHALL write mem_rdata_i into the recorded (r,c) on the cycle mem_rvalid_i is high.
REQ-016 A response write and an out-of-bounds zero write in the same cycle target different elements; both SHALL take effect.
REQ-017 SHALL ignore mem_rvalid_i while no response is outstanding.
REQ-018 In DRAIN and HOLD, mem_req_o SHALL be low.
REQ-019 With zero wait states and all elements in bounds, tile_valid_o SHALL rise TileRows*TileCols+2 cycles after the start cycle.
REQ-020 tile_valid_o SHALL be high only in HOLD, and tile_o SHALL be stable while tile_valid_o is high.
REQ-021 done_o SHALL pulse on the cycle after tile_valid_o && tile_ready_i.
REQ-022 start_i while busy SHALL be ignored, with no queuing.
REQ-023 start_i in the cycle of HOLD->IDLE SHALL be ignored; start is accepted from IDLE only.
REQ-024 When matrix_rows or matrix_cols is 0, all elements SHALL be out of bounds and the block SHALL issue no request; the tile is all zeros.
REQ-025 transpose_i SHALL be honoured only when TileRows == TileCols; otherwise it SHALL be treated as 0.

Reset
REQ-026 Asserting rst_ni low SHALL, asynchronously and at any point including mid-tile:
- force IDLE.
- clear busy_o, mem_req_o, tile_valid_o and done_o to 0.
- clear tile_o to all zeros.
- clear the latched registers and the outstanding-response flag.
REQ-027 After reset release, the block SHALL ignore a late mem_rvalid_i.

Verification
REQ-028 base=0x100, cols=rows=8, origin (2,4), memory[a]=a[7:0], zero waits -> first address 0x114; tile_o[r][c] = 0x14+8r+c; tile_valid_o at start+18.
REQ-029 Same setup with transpose=1 -> tile_o[r][c] = 0x14+8c+r.
REQ-030 rows=cols=5, origin (3,3) -> requests only for (0,0),(0,1),(1,0),(1,1); the other 12 elements are 0; 4 grants counted.
REQ-031 mem_gnt_i low for 3 cycles on element 5 -> address held stable for those cycles; tile data unaffected; tile_valid_o delayed 3 cycles.
REQ-032 tile_ready_i low for 10 cycles in HOLD, with start_i pulsed during that time -> tile_o stable; no new requests; done_o single pulse after ready.
REQ-033 rst_ni low after 7 issues with one response outstanding -> all outputs 0 immediately; a rvalid one cycle after release leaves tile_o zero; the next start runs a full tile correctly.
